alu_muldiv_unit: RTL and testbench
==================================

// Module: alu_muldiv_unit
// PURPOSE
//   Execute-stage consumer of the decoded ALU function for the HI/LO group:
//   Muls/Mulu/Divs/Divu/Mthi/Mtlo. Owns the architectural HI/LO registers,
//   runs iterative multiply and divide, and presents HI/LO to the Mfhi/Mflo
//   result mux. The pipeline stalls on busy; exceptions cancel via flush.
// PARAMETERS
//   WIDTH  32  operand width; HI/LO are WIDTH each; iteration count = WIDTH
// PORTS
//   clock    in   1            single clock, rising edge
//   reset    in   1            synchronous, active-low
//   flush    in   1            abort in-flight op; HI/LO keep pre-op values
//   inValid  in   1            func/a/b valid this cycle
//   inReady  out  1            = ~busy; op accepted on inValid & inReady edge
//   func     in   Alu_Func     decoded ALU function (Alu_Func_* encoding)
//   a        in   WIDTH        rs operand (dividend / multiplicand / move src)
//   b        in   WIDTH        rt operand (divisor / multiplier)
//   busy     out  1            iterative op in progress
//   done     out  1            1-cycle pulse: HI/LO just updated by mul/div
//   hi       out  WIDTH        architectural HI
//   lo       out  WIDTH        architectural LO
// BEHAVIOUR
//   Clock/reset: one clock; reset is synchronous and active-low.
//   Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
//   Accept (edge E0, IDLE): Muls/Mulu -> MUL; Divs/Divu -> DIV; Mthi: hi<=a;
//     Mtlo: lo<=a (no busy, no done). Any other func: no effect, inReady=1.
//   Signed ops latch |a|,|b| plus result-sign flags; unsigned latch raw values.
//   MUL/DIV: one shift-add / restoring-subtract step per cycle, WIDTH cycles
//     (E1..E_WIDTH); then FIXUP one cycle (E_WIDTH+1): sign-correct, write
//     hi/lo, return to IDLE. busy=1 from after E0 through E_WIDTH+1 (WIDTH+1
//     cycles); done=1 in the cycle after E_WIDTH+1 (hi/lo already valid).
//   Mul: {hi,lo} = full 2*WIDTH product (signed or unsigned per func).
//   Div: lo=quotient (truncated toward zero), hi=remainder (sign of dividend).
//   Divide by zero: lo={WIDTH{1}}, hi=a; full latency still taken.
//   Signed overflow (a=MIN_INT, b=-1): lo=MIN_INT, hi=0.
//   inValid while busy: ignored (inReady=0); upstream must hold.
//   flush: highest priority after reset; any state -> IDLE next edge, busy=0,
//     done=0, hi/lo unchanged. flush with inValid in IDLE: op not accepted.
//   reset mid-operation: abort, all outputs to reset values.
//   hi/lo change only on Mthi/Mtlo accept or FIXUP; never mid-iteration.
// CONFIGURATION
//   ALU_MULDIV_FAST_MUL_EN defined: Muls/Mulu use single-cycle combinational
//     multiply; hi/lo written at accept edge E0, busy stays 0, done pulses in
//     cycle after E0. Divide unchanged.
//   Undefined: iterative multiply as above (WIDTH+1 busy cycles).
// STRUCTURE
//   Shared package: Alu_Func encoding (existing), muldiv state encoding
//     (IDLE, MUL, DIV, FIXUP) and type macro, step-counter width = clog2(WIDTH).
//   Sub-module alu_muldiv_divstep: combinational single restoring-division step
//     (remainder, quotient bit). The multiply step is inlined.
// TESTING
//   Mulu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001, done 34
//     cycles after accept (iterative) / 1 cycle (fast build).
//   Muls a=-3 b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; Divs a=-7 b=2 -> lo=-3 hi=-1.
//   Divu a=100 b=0 -> lo=0xFFFFFFFF hi=100; Divs a=0x80000000 b=-1 -> lo=0x80000000 hi=0.
//   Divu 17/5 accepted, inValid held with Mthi during busy -> inReady=0, Mthi
//     accepted after done; final hi=a(Mthi), lo=3.
//   Divs started after Mtlo 0x1234, flush at cycle 10 -> busy=0 next cycle,
//     lo=0x1234 unchanged, no done pulse.
//   reset low at cycle 5 of Mulu -> next cycle hi=lo=0, busy=0, inReady=1.

Source files
------------

// File: rtl/alu_muldiv_unit_pkg.sv
// ---------------------------------------------------------------------------
// alu_muldiv_unit_pkg
//   Shared definitions for the HI/LO multiply/divide unit:
//   - Alu_Func   : decoded ALU function encoding used by the execute stage
//   - muldiv_state_e : sequencer states of the iterative multiply/divide
//   - muldiv_cnt_w   : width of the per-iteration step counter
// ---------------------------------------------------------------------------
package alu_muldiv_unit_pkg;

  typedef enum logic [4:0] {
    Alu_Func_Add,
    Alu_Func_Addu,
    Alu_Func_Sub,
    Alu_Func_Subu,
    Alu_Func_And,
    Alu_Func_Or,
    Alu_Func_Xor,
    Alu_Func_Nor,
    Alu_Func_Slt,
    Alu_Func_Sltu,
    Alu_Func_Sll,
    Alu_Func_Srl,
    Alu_Func_Sra,
    Alu_Func_Lui,
    Alu_Func_Muls,
    Alu_Func_Mulu,
    Alu_Func_Divs,
    Alu_Func_Divu,
    Alu_Func_Mthi,
    Alu_Func_Mtlo,
    Alu_Func_Mfhi,
    Alu_Func_Mflo
  } Alu_Func;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_FIXUP
  } muldiv_state_e;

  // Step counter must hold 0..width-1.
  function automatic int muldiv_cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/alu_muldiv_divstep.sv
// ---------------------------------------------------------------------------
// alu_muldiv_divstep
//   One combinational restoring-division step. The partial remainder is
//   shifted left with the next dividend bit; if the result is not smaller
//   than the divisor it is reduced and the quotient bit is 1.
// Ports
//   i_rem   in  WIDTH  partial remainder before this step
//   i_bit   in  1      next dividend bit (MSB first)
//   i_dsor  in  WIDTH  divisor magnitude
//   o_rem   out WIDTH  partial remainder after this step
//   o_qbit  out 1      quotient bit produced by this step
// ---------------------------------------------------------------------------
module alu_muldiv_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dsor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;

  assign w_shift = {i_rem, i_bit};
  assign o_qbit  = (w_shift >= {1'b0, i_dsor});
  // When the subtraction succeeds the true difference fits in WIDTH bits,
  // so a modular WIDTH-bit subtract yields it exactly. A zero divisor always
  // "succeeds", which walks the dividend into the remainder unchanged.
  assign o_rem   = o_qbit ? (w_shift[WIDTH-1:0] - i_dsor) : w_shift[WIDTH-1:0];

endmodule

// File: rtl/alu_muldiv_unit.sv
// ---------------------------------------------------------------------------
// alu_muldiv_unit
//   Execute-stage HI/LO group: Muls/Mulu/Divs/Divu/Mthi/Mtlo. Owns the
//   architectural HI/LO registers and runs an iterative shift-add multiply
//   and restoring divide (WIDTH steps plus one sign-fixup cycle).
// Configuration
//   ALU_MULDIV_FAST_MUL_EN : when defined, multiplies complete combinationally
//   at the accept edge (no busy, done pulses next cycle). Divide unchanged.
// Ports
//   clock    in   1      rising-edge clock
//   reset    in   1      synchronous, active-low
//   flush    in   1      abort in-flight op; HI/LO keep their values
//   inValid  in   1      func/a/b valid this cycle
//   inReady  out  1      unit idle; op accepted on inValid & inReady edge
//   func     in   Alu_Func decoded ALU function
//   a        in   WIDTH  rs operand (dividend / multiplicand / move source)
//   b        in   WIDTH  rt operand (divisor / multiplier)
//   busy     out  1      iterative op in progress
//   done     out  1      one-cycle pulse: HI/LO just updated by mul/div
//   hi, lo   out  WIDTH  architectural HI / LO
// ---------------------------------------------------------------------------
module alu_muldiv_unit
  import alu_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             inValid,
  output logic             inReady,
  input  Alu_Func          func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int               CNT_W     = muldiv_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  muldiv_state_e      r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi, r_lo;

  // Shared iteration datapath: r_acc is the upper product half / remainder,
  // r_q the multiplier-then-lower-product / dividend-then-quotient.
  logic [WIDTH-1:0]   r_acc, r_q, r_opb;
  logic               r_is_div, r_neg_q, r_neg_r, r_dz;

  logic               w_accept, w_is_mul, w_is_div, w_signed;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH-1:0]   w_div_rem;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_prod_mag, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;

  assign inReady  = (r_state == MD_IDLE);
  assign busy     = ~inReady;
  assign done     = r_done;
  assign hi       = r_hi;
  assign lo       = r_lo;

  assign w_accept = inValid & inReady & ~flush;
  assign w_is_mul = (func == Alu_Func_Muls) | (func == Alu_Func_Mulu);
  assign w_is_div = (func == Alu_Func_Divs) | (func == Alu_Func_Divu);
  assign w_signed = (func == Alu_Func_Muls) | (func == Alu_Func_Divs);
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opb} : '0);

  alu_muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
    .i_rem  (r_acc),
    .i_bit  (r_q[WIDTH-1]),
    .i_dsor (r_opb),
    .o_rem  (w_div_rem),
    .o_qbit (w_qbit)
  );

  // Sign correction applied in FIXUP. MIN_INT / -1 needs no special case:
  // the magnitude quotient 2^(WIDTH-1) negates to itself.
  assign w_prod_mag = {r_acc, r_q};
  assign w_prod     = r_neg_q ? -w_prod_mag : w_prod_mag;
  assign w_quo      = r_dz ? '1 : (r_neg_q ? -r_q : r_q);
  assign w_rem      = r_neg_r ? -r_acc : r_acc;

`ifdef ALU_MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_ea, w_fast_eb, w_fast_prod;

  // Sign-extending to 2*WIDTH makes a modular multiply give the signed product.
  assign w_fast_ea   = {{WIDTH{w_a_neg}}, a};
  assign w_fast_eb   = {{WIDTH{w_b_neg}}, b};
  assign w_fast_prod = w_fast_ea * w_fast_eb;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      MD_IDLE: begin
        if (w_accept) begin
          if (w_is_div) w_next = MD_DIV;
`ifndef ALU_MULDIV_FAST_MUL_EN
          else if (w_is_mul) w_next = MD_MUL;
`endif
        end
      end
      MD_MUL, MD_DIV: begin
        if (r_cnt == LAST_STEP) w_next = MD_FIXUP;
      end
      MD_FIXUP: w_next = MD_IDLE;
      default:  w_next = MD_IDLE;
    endcase
    if (flush) w_next = MD_IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      if (flush || w_accept) begin
        r_cnt <= '0;
      end else if ((r_state == MD_MUL) || (r_state == MD_DIV)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // A flush suppresses every HI/LO write, including a pending FIXUP.
      if (!flush) begin
        if (w_accept) begin
          case (func)
            Alu_Func_Mthi: r_hi <= a;
            Alu_Func_Mtlo: r_lo <= a;
`ifdef ALU_MULDIV_FAST_MUL_EN
            Alu_Func_Muls, Alu_Func_Mulu: begin
              {r_hi, r_lo} <= w_fast_prod;
              r_done       <= 1'b1;
            end
`endif
            default: ;
          endcase
        end
        if (r_state == MD_FIXUP) begin
          r_done <= 1'b1;
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
        end
      end
    end
  end

  // Multiply is commutative, so both ops load |a| into r_q and |b| into r_opb.
  always_ff @(posedge clock) begin
    if (w_accept && (w_is_mul || w_is_div)) begin
      r_acc    <= '0;
      r_q      <= w_a_mag;
      r_opb    <= w_b_mag;
      r_is_div <= w_is_div;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_dz     <= (b == '0);
    end else if (r_state == MD_MUL) begin
      r_acc <= w_mul_sum[WIDTH:1];
      r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
    end else if (r_state == MD_DIV) begin
      r_acc <= w_div_rem;
      r_q   <= {r_q[WIDTH-2:0], w_qbit};
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
`timescale 1ns/1ps
module tb_alu_muldiv_unit;
  import alu_muldiv_unit_pkg::*;

  localparam int W = 32;
`ifdef ALU_MULDIV_FAST_MUL_EN
  localparam bit FAST    = 1'b1;
  localparam int MUL_LAT = 1;
`else
  localparam bit FAST    = 1'b0;
  localparam int MUL_LAT = W + 2;
`endif
  localparam int DIV_LAT = W + 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         inValid = 1'b0;
  Alu_Func      func = Alu_Func_Add;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         inReady, busy, done;
  logic [W-1:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  alu_muldiv_unit #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .inValid (inValid),
    .inReady (inReady),
    .func    (func),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  // Reference arithmetic: returns {hi, lo} for a mul/div.
  function automatic logic [2*W-1:0] ref_result(input Alu_Func f, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy;
    logic [2*W-1:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = '0;
    case (f)
      Alu_Func_Mulu: r = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      Alu_Func_Muls: r = sx * sy;
      Alu_Func_Divu: r = (y == 0) ? {x, {W{1'b1}}} : {x % y, x / y};
      Alu_Func_Divs: begin
        if (y == 0)                                  r = {x, {W{1'b1}}};
        else if (x == 32'h8000_0000 && y == '1)      r = {32'h0, 32'h8000_0000};
        else                                         r = {W'(sx % sy), W'(sx / sy)};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Transaction-level model: an accepted mul/div commits its result
  // WIDTH+1 edges after the accept edge; moves commit at once.
  int unsigned  cyc = 0;
  int unsigned  m_end = 0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;

  always @(posedge clock) begin
    cyc    <= cyc + 1;
    m_done <= 1'b0;
    if (!reset) begin
      m_busy <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (flush) begin
      m_busy <= 1'b0;
    end else if (m_busy) begin
      if (cyc == m_end) begin
        m_busy <= 1'b0;
        m_hi   <= m_phi;
        m_lo   <= m_plo;
        m_done <= 1'b1;
      end
    end else if (inValid) begin
      case (func)
        Alu_Func_Mthi: m_hi <= a;
        Alu_Func_Mtlo: m_lo <= a;
        Alu_Func_Muls, Alu_Func_Mulu, Alu_Func_Divs, Alu_Func_Divu: begin
          if (FAST && (func == Alu_Func_Muls || func == Alu_Func_Mulu)) begin
            {m_hi, m_lo} <= ref_result(func, a, b);
            m_done       <= 1'b1;
          end else begin
            m_busy         <= 1'b1;
            m_end          <= cyc + W + 1;
            {m_phi, m_plo} <= ref_result(func, a, b);
          end
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("model_hi", hi, m_hi);
      chk("model_lo", lo, m_lo);
      chk1("model_busy", busy, m_busy);
      chk1("model_done", done, m_done);
      chk1("model_inReady", inReady, ~m_busy);
    end
  end

  // Called at a negedge; holds the op until an edge accepts it. n = edges used.
  task automatic issue(input Alu_Func f, input logic [W-1:0] x, input logic [W-1:0] y, output int n);
    logic rdy;
    inValid = 1'b1;
    func    = f;
    a       = x;
    b       = y;
    n       = 0;
    do begin
      rdy = inReady;
      @(negedge clock);
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout: inReady stayed %b, required 1", inReady);
    end
    inValid = 1'b0;
    func    = Alu_Func_Add;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk1("done_seen", done, 1'b1);
  endtask

  task automatic run_op(input string nm, input Alu_Func f, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input int elat);
    int n, k;
    issue(f, x, y, n);
    wait_done(k);
    chk_int({nm, "_lat"}, n + k, elat);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, seen;
    repeat (3) @(negedge clock);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk1("reset_inReady", inReady, 1'b1);
    reset  = 1'b1;
    chk_en = 1'b1;
    @(negedge clock);

    run_op("mulu_max", Alu_Func_Mulu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
    run_op("muls_m3x7", Alu_Func_Muls, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
    run_op("muls_minxmin", Alu_Func_Muls, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, MUL_LAT);
    run_op("mulu_shift", Alu_Func_Mulu, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780, MUL_LAT);
    run_op("divs_m7d2", Alu_Func_Divs, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    run_op("divs_7dm2", Alu_Func_Divs, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT);
    run_op("divu_by0", Alu_Func_Divu, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, DIV_LAT);
    run_op("divs_by0", Alu_Func_Divs, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, DIV_LAT);
    run_op("divs_ovf", Alu_Func_Divs, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIV_LAT);
    run_op("divu_by1", Alu_Func_Divu, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF, DIV_LAT);

    // Divide, then a move held while the unit is busy.
    issue(Alu_Func_Divu, 32'd17, 32'd5, n);
    chk1("hold_busy", busy, 1'b1);
    issue(Alu_Func_Mthi, 32'hCAFE_0001, 32'h0, n);
    chk_int("hold_wait", n, W + 2);
    chk("hold_hi", hi, 32'hCAFE_0001);
    chk("hold_lo", lo, 32'h0000_0003);

    // Unrelated function: accepted immediately, no effect.
    issue(Alu_Func_Add, 32'd1, 32'd2, n);
    chk_int("other_wait", n, 1);
    chk("other_hi", hi, 32'hCAFE_0001);
    chk("other_lo", lo, 32'h0000_0003);

    // Flush mid-divide.
    issue(Alu_Func_Mtlo, 32'h0000_1234, 32'h0, n);
    issue(Alu_Func_Divs, 32'hFFFF_FF9C, 32'd7, n);
    repeat (8) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk1("flush_busy", busy, 1'b0);
    chk1("flush_done", done, 1'b0);
    chk("flush_lo", lo, 32'h0000_1234);
    chk("flush_hi", hi, 32'hCAFE_0001);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) seen++;
    end
    chk_int("flush_no_done", seen, 0);

    // Flush with a move offered in IDLE: not accepted.
    flush   = 1'b1;
    inValid = 1'b1;
    func    = Alu_Func_Mthi;
    a       = 32'h5555_5555;
    @(negedge clock);
    flush   = 1'b0;
    inValid = 1'b0;
    func    = Alu_Func_Add;
    chk("flush_idle_hi", hi, 32'hCAFE_0001);

    // Reset in the middle of a multiply.
    issue(Alu_Func_Mulu, 32'h1111, 32'h2222, n);
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rstmid_hi", hi, 32'h0);
    chk("rstmid_lo", lo, 32'h0);
    chk1("rstmid_busy", busy, 1'b0);
    chk1("rstmid_inReady", inReady, 1'b1);
    reset = 1'b1;
    @(negedge clock);

    run_op("divu_17d5", Alu_Func_Divu, 32'd17, 32'd5, 32'd2, 32'd3, DIV_LAT);

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
